// File: rtl/penguin_lane_ctrl.sv
// Penguin lane controller: debounces left/right buttons once per video frame
// and slides the penguin x position between three fixed lanes at a constant step.
module penguin_lane_ctrl #(
  parameter logic [15:0] LANE_LEFT_X  = 16'd276,
  parameter logic [15:0] LANE_MID_X   = 16'd576,
  parameter logic [15:0] LANE_RIGHT_X = 16'd876,
  parameter logic [15:0] STEP         = 16'd4,
  parameter int unsigned HOLD_FRAMES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_v_sync,
  input  logic        i_btn_left,
  input  logic        i_btn_right,
  input  logic        i_game_over,
  output logic [15:0] o_penguin_x,
  output logic [1:0]  o_lane,
  output logic        o_moving,
  output logic        o_at_lane
);

  localparam int unsigned XW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_MAX  = 4'd15;
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    target_q, target_d;
  logic          moving_q;
  logic          at_lane_q;
  logic          arrive;
  logic          v_sync_q;
  logic          tick;
  logic [CW-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic          press_l, press_r;
  logic [XW-1:0] tgt_x;

  function automatic logic [XW-1:0] lane_x(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_x = LANE_LEFT_X;
      2'd1:    lane_x = LANE_MID_X;
      default: lane_x = LANE_RIGHT_X;
    endcase
  endfunction

  // One tick per rising v_sync edge, suppressed entirely while the game is frozen
  assign tick = i_v_sync & ~v_sync_q & ~i_game_over;

  // Saturating hold counters; a press fires only on the tick the count first reaches the hold length
  always_comb begin
    cnt_l_d = '0;
    cnt_r_d = '0;
    if (i_btn_left)  cnt_l_d = (cnt_l_q == CNT_MAX) ? CNT_MAX : cnt_l_q + 4'd1;
    if (i_btn_right) cnt_r_d = (cnt_r_q == CNT_MAX) ? CNT_MAX : cnt_r_q + 4'd1;
    press_l = tick & i_btn_left  & (cnt_l_d == HOLD_CNT) & (cnt_l_q != HOLD_CNT);
    press_r = tick & i_btn_right & (cnt_r_d == HOLD_CNT) & (cnt_r_q != HOLD_CNT);
  end

  assign tgt_x = lane_x(target_q);

  // Next-state: start a one-lane hop from IDLE, step toward the target while moving
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    lane_d   = lane_q;
    target_d = target_q;
    arrive   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (press_l && !press_r && lane_q != 2'd0) begin
            state_d  = MOVE_L;
            target_d = lane_q - 2'd1;
          end else if (press_r && !press_l && lane_q < 2'd2) begin
            state_d  = MOVE_R;
            target_d = lane_q + 2'd1;
          end
        end
        MOVE_L, MOVE_R: begin
          x_d = (state_q == MOVE_L) ? x_q - STEP : x_q + STEP;
          if (x_d == tgt_x) begin
            state_d = IDLE;
            lane_d  = target_q;
            arrive  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, position and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      x_q       <= LANE_MID_X;
      lane_q    <= 2'd1;
      target_q  <= 2'd1;
      moving_q  <= 1'b0;
      at_lane_q <= 1'b0;
      v_sync_q  <= 1'b0;
      cnt_l_q   <= '0;
      cnt_r_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      lane_q    <= lane_d;
      target_q  <= target_d;
      moving_q  <= (state_d != IDLE);
      at_lane_q <= arrive;
      v_sync_q  <= i_v_sync;
      if (tick) begin
        cnt_l_q <= cnt_l_d;
        cnt_r_q <= cnt_r_d;
      end
    end
  end

  assign o_penguin_x = x_q;
  assign o_lane      = lane_q;
  assign o_moving    = moving_q;
  assign o_at_lane   = at_lane_q;

endmodule
